// File: rtl/rs_file.sv
// Reservation-station slot storage between dispatch and stage_issue.
// Handles in-order lane allocation into free slots, CDB wakeup, issue clears and mispredict flush.
package rs_pkg;
  localparam int RS_SZ  = 16;
  localparam int N      = 3;
  localparam int CDB_SZ = 3;
  localparam int RS_IDX = $clog2(RS_SZ);
  localparam int CNT_W  = $clog2(RS_SZ + 1);
  localparam int TAG_W  = 6;
  localparam int OP_W   = 8;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest_tag;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_ready;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_ready;
  } rs_entry_t;

  typedef struct packed {
    logic [CDB_SZ-1:0]            valid;
    logic [CDB_SZ-1:0][TAG_W-1:0] tags;
  } cdb_packet_t;
endpackage

module rs_file
  import rs_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N-1:0]                 disp_valid,
  input  rs_entry_t [N-1:0]            disp_entries,
  input  cdb_packet_t                  cdb,
  input  logic [N-1:0]                 clear_valid,
  input  logic [N-1:0][RS_IDX-1:0]     clear_idxs,
  input  logic                         mispredict,
  output rs_entry_t [RS_SZ-1:0]        entries,
  output logic [CNT_W-1:0]             free_count
);

  rs_entry_t [RS_SZ-1:0] entries_next;
  logic [CNT_W-1:0]      free_next;
  logic [CNT_W-1:0]      disp_cnt;
  logic                  overflow;

  function automatic logic tag_hit(input cdb_packet_t c, input logic [TAG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < CDB_SZ; j++)
      if (c.valid[j] && c.tags[j] == tag) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    logic [RS_SZ-1:0] taken;
    logic             placed;
    rs_entry_t        e;
    // NOTE: every comb output gets a default first so no path can leave it unassigned and infer a latch.
    entries_next = entries;
    taken        = '0;
    e            = '0;

    // Wakeup sees only currently valid slots; ready bits are sticky.
    for (int s = 0; s < RS_SZ; s++) begin
      if (entries[s].valid) begin
        if (tag_hit(cdb, entries[s].src1_tag)) entries_next[s].src1_ready = 1'b1;
        if (tag_hit(cdb, entries[s].src2_tag)) entries_next[s].src2_ready = 1'b1;
      end
    end

    for (int i = 0; i < N; i++)
      if (clear_valid[i]) entries_next[clear_idxs[i]].valid = 1'b0;

    // Free set comes from the current state, so slots cleared this cycle are not reused yet.
    for (int i = 0; i < N; i++) begin
      placed = 1'b0;
      if (disp_valid[i]) begin
        for (int s = 0; s < RS_SZ; s++) begin
          if (!placed && !entries[s].valid && !taken[s]) begin
            e            = disp_entries[i];
            e.valid      = 1'b1;
            e.src1_ready = e.src1_ready | tag_hit(cdb, e.src1_tag);
            e.src2_ready = e.src2_ready | tag_hit(cdb, e.src2_tag);
            entries_next[s] = e;
            taken[s]        = 1'b1;
            placed          = 1'b1;
          end
        end
      end
    end

    if (mispredict)
      for (int s = 0; s < RS_SZ; s++) entries_next[s].valid = 1'b0;

    free_next = '0;
    for (int s = 0; s < RS_SZ; s++)
      free_next = free_next + CNT_W'(!entries_next[s].valid);
  end

  always_comb begin
    disp_cnt = '0;
    for (int i = 0; i < N; i++) disp_cnt = disp_cnt + CNT_W'(disp_valid[i]);
    overflow = !mispredict && (disp_cnt > free_count);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the slot array is reset too; downstream reads fields, not just valid, after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries    <= '0;
      free_count <= CNT_W'(RS_SZ);
    end else begin
      entries    <= entries_next;
      free_count <= free_next;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !overflow)
    else $error("rs_file: dispatch exceeds free slots");

endmodule

// File: tb/tb_rs_file.sv
// Directed bench for rs_file: allocation order, wakeup, forwarding, clear rules, flush and async reset.
module tb_rs_file;
  import rs_pkg::*;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [N-1:0]             disp_valid;
  rs_entry_t [N-1:0]        disp_entries;
  cdb_packet_t              cdb;
  logic [N-1:0]             clear_valid;
  logic [N-1:0][RS_IDX-1:0] clear_idxs;
  logic                     mispredict;
  rs_entry_t [RS_SZ-1:0]    entries;
  logic [CNT_W-1:0]         free_count;

  int checks = 0;
  int errors = 0;

  rs_file dut (
    .clock        (clock),
    .reset        (reset),
    .disp_valid   (disp_valid),
    .disp_entries (disp_entries),
    .cdb          (cdb),
    .clear_valid  (clear_valid),
    .clear_idxs   (clear_idxs),
    .mispredict   (mispredict),
    .entries      (entries),
    .free_count   (free_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic rs_entry_t mk(input logic [7:0] op, input logic [5:0] d,
                                   input logic [5:0] s1, input logic r1,
                                   input logic [5:0] s2, input logic r2);
    rs_entry_t e;
    e = '{valid: 1'b0, op: op, dest_tag: d, src1_tag: s1, src1_ready: r1,
          src2_tag: s2, src2_ready: r2};
    return e;
  endfunction

  function automatic logic [31:0] valid_mask();
    logic [31:0] m;
    m = '0;
    for (int s = 0; s < RS_SZ; s++) m[s] = entries[s].valid;
    return m;
  endfunction

  task automatic idle();
    disp_valid   = '0;
    disp_entries = '0;
    cdb          = '0;
    clear_valid  = '0;
    clear_idxs   = '0;
    mispredict   = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled just after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    @(negedge clock);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    // Test 1: reset state
    check("rst_mask", valid_mask(), 32'h0);
    check("rst_free", 32'(free_count), 32'd16);
    check("rst_slot0", 32'(entries[0]), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Test 2: three lanes into empty RS, lane order
    disp_valid      = 3'b111;
    disp_entries[0] = mk(8'd1, 6'd10, 6'd1, 1'b1, 6'd2, 1'b1);
    disp_entries[1] = mk(8'd2, 6'd11, 6'd1, 1'b1, 6'd2, 1'b1);
    disp_entries[2] = mk(8'd3, 6'd12, 6'd1, 1'b1, 6'd2, 1'b1);
    step();
    check("alloc_mask", valid_mask(), 32'h7);
    check("alloc_free", 32'(free_count), 32'd13);
    check("alloc_order", {8'(entries[0].op), 8'(entries[1].op), 8'(entries[2].op)}, 32'h010203);

    // Flush to start wakeup scenario from empty
    mispredict = 1'b1;
    step();
    check("flush1_mask", valid_mask(), 32'h0);
    check("flush1_free", 32'(free_count), 32'd16);

    disp_valid      = 3'b111;
    disp_entries[0] = mk(8'd4, 6'd20, 6'd3, 1'b1, 6'd4, 1'b1);
    disp_entries[1] = mk(8'd5, 6'd21, 6'd7, 1'b0, 6'd5, 1'b0);
    disp_entries[2] = mk(8'd6, 6'd22, 6'd8, 1'b0, 6'd7, 1'b0);
    step();
    // Test 3: wakeup on tag 7; lane 2 carries tag 8 but is not valid
    cdb.valid   = 3'b001;
    cdb.tags[0] = 6'd7;
    cdb.tags[2] = 6'd8;
    step();
    check("wake_s1r1", 32'(entries[1].src1_ready), 32'd1);
    check("wake_s1r2", 32'(entries[1].src2_ready), 32'd0);
    check("wake_s2r1", 32'(entries[2].src1_ready), 32'd0);
    check("wake_s2r2", 32'(entries[2].src2_ready), 32'd1);

    // Test 4: same-cycle forwarding into slot 3
    disp_valid      = 3'b010;
    disp_entries[0] = mk(8'hAA, 6'd1, 6'd1, 1'b0, 6'd1, 1'b0);
    disp_entries[1] = mk(8'd9, 6'd23, 6'd11, 1'b1, 6'd9, 1'b0);
    disp_entries[2] = mk(8'hBB, 6'd1, 6'd1, 1'b0, 6'd1, 1'b0);
    cdb.valid   = 3'b100;
    cdb.tags[2] = 6'd9;
    step();
    check("fwd_mask", valid_mask(), 32'hF);
    check("fwd_free", 32'(free_count), 32'd12);
    check("fwd_op", 32'(entries[3].op), 32'd9);
    check("fwd_r2", 32'(entries[3].src2_ready), 32'd1);

    // Test 5: clear 0,2 while dispatching two lanes; freed slots not reused yet
    clear_valid     = 3'b011;
    clear_idxs[0]   = 4'd0;
    clear_idxs[1]   = 4'd2;
    disp_valid      = 3'b011;
    disp_entries[0] = mk(8'd7, 6'd24, 6'd1, 1'b1, 6'd1, 1'b1);
    disp_entries[1] = mk(8'd8, 6'd25, 6'd12, 1'b0, 6'd13, 1'b1);
    step();
    check("clr_mask", valid_mask(), 32'h3A);
    check("clr_free", 32'(free_count), 32'd12);
    check("clr_ops", {8'(entries[4].op), 8'(entries[5].op)}, 32'h0708);

    // Freed slot 0 is reused the cycle after, via non-contiguous lane 2
    disp_valid      = 3'b100;
    disp_entries[2] = mk(8'd10, 6'd26, 6'd1, 1'b1, 6'd1, 1'b1);
    step();
    check("reuse_mask", valid_mask(), 32'h3B);
    check("reuse_op", 32'(entries[0].op), 32'd10);
    check("reuse_free", 32'(free_count), 32'd11);

    // Duplicate clear of slot 1, and clear of slot 5 beats a CDB hit on its src1
    clear_valid   = 3'b111;
    clear_idxs[0] = 4'd1;
    clear_idxs[1] = 4'd1;
    clear_idxs[2] = 4'd5;
    cdb.valid     = 3'b001;
    cdb.tags[0]   = 6'd12;
    step();
    check("dup_mask", valid_mask(), 32'h19);
    check("dup_free", 32'(free_count), 32'd13);
    check("clr_beats_cdb", 32'(entries[5].valid), 32'd0);

    // Clearing an invalid slot is a no-op
    clear_valid   = 3'b001;
    clear_idxs[0] = 4'd9;
    step();
    check("nop_mask", valid_mask(), 32'h19);
    check("nop_free", 32'(free_count), 32'd13);

    // Test 6: mispredict wins over dispatch and CDB
    mispredict      = 1'b1;
    disp_valid      = 3'b111;
    disp_entries[0] = mk(8'd11, 6'd1, 6'd3, 1'b0, 6'd3, 1'b0);
    disp_entries[1] = mk(8'd12, 6'd1, 6'd3, 1'b0, 6'd3, 1'b0);
    disp_entries[2] = mk(8'd13, 6'd1, 6'd3, 1'b0, 6'd3, 1'b0);
    cdb.valid       = 3'b001;
    cdb.tags[0]     = 6'd3;
    step();
    check("mp_mask", valid_mask(), 32'h0);
    check("mp_free", 32'(free_count), 32'd16);

    // Refill, then assert reset mid-dispatch
    disp_valid = 3'b111;
    step();
    check("refill_mask", valid_mask(), 32'h7);
    disp_valid = 3'b111;
    reset      = 1'b0;
    #1;
    check("async_mask", valid_mask(), 32'h0);
    check("async_free", 32'(free_count), 32'd16);
    @(posedge clock);
    #1;
    check("held_mask", valid_mask(), 32'h0);
    check("held_slot0", 32'(entries[0]), 32'h0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    step();
    check("post_free", 32'(free_count), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
